// File: rtl/voxel_pkg.sv
// Shared types and default sizing for the voxel RAM arbiter.
package voxel_pkg;

    localparam int DEF_ADDR_BITS = 15;
    localparam int DEF_NUM_REQ   = 4;

    typedef enum logic [1:0] {
        PH_TRACE = 2'b00,
        PH_DRAIN = 2'b01,
        PH_LOAD  = 2'b10
    } arb_phase_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: highest priority is the requester after the last grant.
module rr_arbiter
    import voxel_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] ptr;

    function automatic int wrap_idx(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        return (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (en && !gnt_any && req[wrap_idx(ptr, k)]) begin
                gnt[wrap_idx(ptr, k)] = 1'b1;
                gnt_idx               = IDX_W'(wrap_idx(ptr, k));
                gnt_any               = 1'b1;
            end
        end
    end

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/voxel_ram_arbiter.sv
// Arbitrates ray-traversal reads and scene-load writes onto a single voxel RAM.
// Optional per-requester grant counters are built when VOXEL_ARB_STATS_EN is defined.
module voxel_ram_arbiter
    import voxel_pkg::*;
#(
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int READ_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_mode,
    input  logic                              ld_we,
    input  logic [ADDR_BITS-1:0]              ld_waddr,
    input  logic                              ld_wdata,
    input  logic [NUM_REQ-1:0]                rd_req,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0] rd_addr,
    output logic [NUM_REQ-1:0]                rd_gnt,
    output logic [NUM_REQ-1:0]                rd_rvalid,
    output logic                              rd_rdata,
    output logic [ADDR_BITS-1:0]              ram_raddr,
    input  logic                              ram_rdata,
    output logic                              ram_we,
    output logic [ADDR_BITS-1:0]              ram_waddr,
    output logic                              ram_wdata,
    output logic [1:0]                        phase,
    output logic                              wr_drop_err,
    output logic [NUM_REQ-1:0][15:0]          stat_grants
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_phase_e           state;
    logic                 arb_en;
    logic                 gnt_any;
    logic                 in_flight;
    logic [IDX_W-1:0]     gnt_idx;
    logic [ADDR_BITS-1:0] last_raddr_p0;
    logic [NUM_REQ-1:0]   tag_p [READ_LATENCY];

    assign arb_en = (state == PH_TRACE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (arb_en),
        .req     (rd_req),
        .gnt     (rd_gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Stage p0: address issue; the RAM sees the granted address in the grant cycle.
    assign ram_raddr = gnt_any ? rd_addr[gnt_idx] : last_raddr_p0;

    always_ff @(posedge clk) begin
        if (gnt_any) begin
            last_raddr_p0 <= rd_addr[gnt_idx];
        end
    end

    // Stage p1..pN: one-hot requester tags travel alongside the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                tag_p[k] <= '0;
            end
        end else begin
            tag_p[0] <= rd_gnt;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_p[k] <= tag_p[k-1];
            end
        end
    end

    always_comb begin
        in_flight = 1'b0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            in_flight = in_flight | (|tag_p[k]);
        end
    end

    assign rd_rvalid = tag_p[READ_LATENCY-1];
    assign rd_rdata  = ram_rdata;

    // Write port is gated by state so an asynchronous reset kills ram_we at once.
    assign ram_we    = ld_we & (state == PH_LOAD);
    assign ram_waddr = ld_waddr;
    assign ram_wdata = ld_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PH_TRACE;
            wr_drop_err <= 1'b0;
        end else begin
            if (ld_we && state != PH_LOAD) begin
                wr_drop_err <= 1'b1;
            end
            case (state)
                PH_TRACE: begin
                    if (load_mode) state <= PH_DRAIN;
                end
                PH_DRAIN: begin
                    if (!load_mode)      state <= PH_TRACE;
                    else if (!in_flight) state <= PH_LOAD;
                end
                PH_LOAD: begin
                    if (!load_mode) state <= PH_TRACE;
                end
                default: state <= PH_TRACE;
            endcase
        end
    end

    assign phase = state;

`ifdef VOXEL_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rd_gnt[i]) begin
                    stat_grants[i] <= sat_inc(stat_grants[i]);
                end
            end
        end
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_voxel_ram_arbiter.sv
// Self-checking bench for voxel_ram_arbiter against a cycle-level reference model.
module tb_voxel_ram_arbiter;

    localparam int AB = 15;
    localparam int NR = 4;
`ifdef VOXEL_ARB_STATS_EN
    localparam int NSTAT = 70000;
`else
    localparam int NSTAT = 200;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 load_mode = 1'b0;
    logic                 ld_we = 1'b0;
    logic [AB-1:0]        ld_waddr = '0;
    logic                 ld_wdata = 1'b0;
    logic [NR-1:0]        rd_req = '0;
    logic [NR-1:0][AB-1:0] rd_addr = '0;
    logic [NR-1:0]        rd_gnt;
    logic [NR-1:0]        rd_rvalid;
    logic                 rd_rdata;
    logic [AB-1:0]        ram_raddr;
    logic                 ram_rdata;
    logic                 ram_we;
    logic [AB-1:0]        ram_waddr;
    logic                 ram_wdata;
    logic [1:0]           phase;
    logic                 wr_drop_err;
    logic [NR-1:0][15:0]  stat_grants;

    voxel_ram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_mode   (load_mode),
        .ld_we       (ld_we),
        .ld_waddr    (ld_waddr),
        .ld_wdata    (ld_wdata),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_gnt      (rd_gnt),
        .rd_rvalid   (rd_rvalid),
        .rd_rdata    (rd_rdata),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata),
        .ram_we      (ram_we),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .phase       (phase),
        .wr_drop_err (wr_drop_err),
        .stat_grants (stat_grants)
    );

    always #5 clk = ~clk;

    // Initial scene is a fixed address hash; the RAM stores writes relative to it.
    function automatic logic scene_bit(input logic [AB-1:0] a);
        return a[0] ^ a[3] ^ a[7] ^ a[11] ^ a[14];
    endfunction

    bit ram_ovl [1 << AB];
    always @(posedge clk) begin
        if (ram_we) ram_ovl[ram_waddr] <= ram_wdata ^ scene_bit(ram_waddr);
        ram_rdata <= ram_ovl[ram_raddr] ^ scene_bit(ram_raddr);
    end

    // Reference model state
    int            m_phase;
    int            m_last;
    logic [NR-1:0] m_rv;
    logic          m_rdata;
    bit            m_drop;
    int            m_stat [NR];
    logic [AB-1:0] m_raddr;
    bit            m_have_addr;
    logic [NR-1:0] m_gnt_last;
    bit            mdl_wr  [1 << AB];
    bit            mdl_val [1 << AB];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_read(input int a);
        return mdl_wr[a] ? mdl_val[a] : scene_bit(AB'(a));
    endfunction

    task automatic reset_model();
        m_phase    = 0;
        m_last     = NR - 1;
        m_rv       = '0;
        m_rdata    = 1'b0;
        m_drop     = 1'b0;
        m_gnt_last = '0;
        for (int i = 0; i < NR; i++) m_stat[i] = 0;
    endtask

    // One clock cycle: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        int            g;
        logic [NR-1:0] eg;
        logic [63:0]   es;
        bit            infl;
        #1;
        g  = -1;
        eg = '0;
        if (m_phase == 0) begin
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && rd_req[(m_last + k) % NR]) g = (m_last + k) % NR;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("rd_gnt", rd_gnt, eg);
        chk("rd_rvalid", rd_rvalid, m_rv);
        if (m_rv != '0) chk("rd_rdata", rd_rdata, m_rdata);
        chk("ram_we", ram_we, (m_phase == 2) && ld_we);
        if (ld_we) begin
            chk("ram_waddr", ram_waddr, ld_waddr);
            chk("ram_wdata", ram_wdata, ld_wdata);
        end
        if (g >= 0) begin
            m_raddr     = rd_addr[g];
            m_have_addr = 1'b1;
        end
        if (m_have_addr) chk("ram_raddr", ram_raddr, m_raddr);

        infl    = (m_rv != '0);
        m_rdata = (g >= 0) ? model_read(int'(rd_addr[g])) : 1'b0;
        m_rv    = eg;
        if (ld_we) begin
            if (m_phase == 2) begin
                mdl_wr[ld_waddr]  = 1'b1;
                mdl_val[ld_waddr] = ld_wdata;
            end else begin
                m_drop = 1'b1;
            end
        end
        if (g >= 0) begin
            m_last = g;
            if (m_stat[g] < 65535) m_stat[g]++;
        end
        case (m_phase)
            0: if (load_mode) m_phase = 1;
            1: if (!load_mode) m_phase = 0; else if (!infl) m_phase = 2;
            default: if (!load_mode) m_phase = 0;
        endcase
        m_gnt_last = eg;

        @(posedge clk);
        #1;
        chk("phase", phase, m_phase);
        chk("wr_drop_err", wr_drop_err, m_drop);
        es = '0;
`ifdef VOXEL_ARB_STATS_EN
        for (int i = 0; i < NR; i++) es[i*16 +: 16] = m_stat[i][15:0];
`endif
        chk("stat_grants", stat_grants, es);
    endtask

    initial begin
        reset_model();
        m_have_addr = 1'b0;
        m_raddr     = '0;
        ld_we       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", phase, 2'b00);
        chk("rst_rvalid", rd_rvalid, '0);
        chk("rst_gnt", rd_gnt, '0);
        chk("rst_drop", wr_drop_err, 1'b0);
        chk("rst_stats", stat_grants, '0);
        chk("rst_ram_we", ram_we, 1'b0);
        ld_we = 1'b0;
        rst_n = 1'b1;
        tick();

        // All four requesting continuously: 0,1,2,3,0
        rd_req = 4'hF;
        for (int i = 0; i < NR; i++) rd_addr[i] = AB'($urandom);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_order", rd_gnt, 4'b0001 << (k % 4));
            tick();
        end
        rd_req = '0;
        tick();

        // Single requester, address 5
        rd_req     = 4'b0001;
        rd_addr[0] = AB'(5);
        #1;
        chk("single_gnt", rd_gnt, 4'b0001);
        chk("single_raddr", ram_raddr, 5);
        tick();
        rd_req = '0;
        chk("single_rvalid", rd_rvalid, 4'b0001);
        chk("single_rdata", rd_rdata, scene_bit(AB'(5)));
        tick();

        // Random trace traffic, requests held until granted
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_gnt_last[i]) rd_req[i] = 1'b0;
                if (!rd_req[i] && $urandom_range(0, 2) == 0) begin
                    rd_req[i]  = 1'b1;
                    rd_addr[i] = AB'($urandom);
                end
            end
            tick();
        end
        rd_req = '0;
        tick();

        // Loader write outside LOAD is dropped
        ld_we    = 1'b1;
        ld_waddr = AB'(123);
        ld_wdata = 1'b1;
        tick();
        ld_we = 1'b0;
        chk("drop_err_set", wr_drop_err, 1'b1);

        // load_mode rise together with a request: grant issued, then DRAIN, LOAD
        rd_req     = 4'b0001;
        rd_addr[0] = AB'(123);
        load_mode  = 1'b1;
        #1;
        chk("rise_gnt", rd_gnt, 4'b0001);
        tick();
        rd_req = 4'b0010;
        chk("drain_phase", phase, 2'b01);
        tick();
        chk("drain_hold", phase, 2'b01);
        tick();
        chk("load_phase", phase, 2'b10);
        rd_req = '0;

        // Same write inside LOAD lands, then reads back as 1
        ld_we = 1'b1;
        #1;
        chk("load_we", ram_we, 1'b1);
        tick();
        ld_we     = 1'b0;
        load_mode = 1'b0;
        tick();
        chk("back_trace", phase, 2'b00);
        rd_req     = 4'b0001;
        rd_addr[0] = AB'(123);
        tick();
        rd_req = '0;
        chk("readback_rdata", rd_rdata, 1'b1);
        tick();

        // Reset in the middle of LOAD kills ram_we without a clock edge
        load_mode = 1'b1;
        repeat (3) tick();
        chk("load_again", phase, 2'b10);
        ld_we = 1'b1;
        #1;
        chk("midload_we", ram_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midload_rst_we", ram_we, 1'b0);
        chk("midload_rst_phase", phase, 2'b00);
        ld_we     = 1'b0;
        load_mode = 1'b0;
        reset_model();
        #1;
        rst_n = 1'b1;
        tick();

        // Reset in the middle of DRAIN with a read in flight
        ld_we = 1'b1;
        tick();
        ld_we      = 1'b0;
        rd_req     = 4'b0100;
        rd_addr[2] = AB'($urandom);
        load_mode  = 1'b1;
        tick();
        rd_req = '0;
        chk("pre_rst_drain", phase, 2'b01);
        chk("pre_rst_drop", wr_drop_err, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("middrain_phase", phase, 2'b00);
        chk("middrain_rvalid", rd_rvalid, '0);
        chk("middrain_drop", wr_drop_err, 1'b0);
        load_mode = 1'b0;
        reset_model();
        #1;
        rst_n = 1'b1;
        tick();

        // Random mix of traffic, mode changes and loader writes in a small address window
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_gnt_last[i]) rd_req[i] = 1'b0;
                if (!rd_req[i] && $urandom_range(0, 2) == 0) begin
                    rd_req[i]  = 1'b1;
                    rd_addr[i] = AB'($urandom_range(0, 63));
                end
            end
            if ($urandom_range(0, 7) == 0) load_mode = ~load_mode;
            ld_we    = ($urandom_range(0, 3) == 0);
            ld_waddr = AB'($urandom_range(0, 63));
            ld_wdata = 1'($urandom);
            tick();
        end
        ld_we     = 1'b0;
        load_mode = 1'b0;
        rd_req    = '0;
        repeat (2) tick();

        // Grant counter for requester 2
        rd_req     = 4'b0100;
        rd_addr[2] = AB'($urandom);
        for (int n = 0; n < NSTAT; n++) tick();
        rd_req = '0;
        tick();
`ifdef VOXEL_ARB_STATS_EN
        chk("stat_sat", stat_grants[2], 16'hFFFF);
`else
        chk("stat_off", stat_grants[2], 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
